dca_matrix_load_sequencer: RTL and testbench

//  Sequences one DCA matrix-load instruction into per-row memory read requests.

---
 rtl/dca_matrix_load_sequencer.sv | 174 +++++++++++++++++
 tb/tb_dca_matrix_load_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_load_sequencer.sv
// dca_matrix_load_sequencer
//  Turns one DCA matrix-load instruction into a stream of per-row read
//  requests tagged {last, row_idx}. It bounds the number of unanswered reads,
//  consumes the tagged row responses, and pulses done once the last row has
//  been consumed.
//  Optional build macro: DCA_LOAD_SEQ_ROW_CHECK_EN adds an in-order response
//  tag checker that drives the sticky seq_error flag.
module dca_matrix_load_sequencer #(
  parameter int BW_ADDR         = 32,
  parameter int BW_STRIDE_LS3   = 24,
  parameter int BW_NUM_ROW_M1   = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [BW_ADDR-1:0]       inst_addr,
  input  logic [BW_STRIDE_LS3-1:0] inst_stride_ls3,
  input  logic [BW_NUM_ROW_M1-1:0] inst_num_row_m1,
  output logic                     rreq_valid,
  input  logic                     rreq_ready,
  output logic [BW_ADDR-1:0]       rreq_addr,
  output logic [BW_NUM_ROW_M1:0]   rreq_txn_info,
  input  logic                     rresp_valid,
  output logic                     rresp_ready,
  input  logic [BW_NUM_ROW_M1:0]   rresp_txn_info,
  output logic                     busy,
  output logic                     done,
  output logic                     seq_error
);

  localparam int BW_TXN_INFO    = BW_NUM_ROW_M1 + 1;
  localparam int BW_OUTSTANDING = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [BW_OUTSTANDING-1:0] OUT_MAX = BW_OUTSTANDING'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic [BW_ADDR-1:0]        addr_reg;
  logic [BW_STRIDE_LS3-1:0]  stride_reg;
  logic [BW_NUM_ROW_M1-1:0]  num_row_reg;
  logic [BW_NUM_ROW_M1-1:0]  row_idx_reg;
  logic [BW_OUTSTANDING-1:0] outstanding_reg;
  logic                      done_reg;

  logic                      inst_fire;
  logic                      req_fire;
  logic                      resp_fire;
  logic                      req_last;
  logic                      resp_last;
  logic [BW_ADDR-1:0]        stride_bytes;
  logic [BW_TXN_INFO-1:0]    req_tag;

  // The stride is given in 8-byte units; the address adder wraps naturally.
  assign stride_bytes = BW_ADDR'({stride_reg, 3'b000});
  assign req_last     = (row_idx_reg == num_row_reg);
  assign req_tag      = {req_last, row_idx_reg};
  assign resp_last    = rresp_txn_info[BW_NUM_ROW_M1];

  assign inst_fire = inst_valid && inst_ready;
  assign req_fire  = rreq_valid && rreq_ready;
  assign resp_fire = rresp_valid && rresp_ready;

  // Address and tag are only driven while a request is presented.
  assign rreq_addr     = rreq_valid ? addr_reg : '0;
  assign rreq_txn_info = rreq_valid ? req_tag : '0;
  assign rresp_ready   = (state_reg != S_IDLE) && (outstanding_reg != '0);
  assign busy          = (state_reg != S_IDLE);
  assign done          = done_reg;

  // State register
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    inst_ready = 1'b0;
    rreq_valid = 1'b0;
    case (state_reg)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        // Requests pause as soon as the outstanding window is full.
        rreq_valid = (outstanding_reg < OUT_MAX);
        if (rreq_valid && rreq_ready && req_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (resp_fire && resp_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Instruction fields, row cursor and outstanding-read count
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      addr_reg        <= '0;
      stride_reg      <= '0;
      num_row_reg     <= '0;
      row_idx_reg     <= '0;
      outstanding_reg <= '0;
    end else begin
      if (inst_fire) begin
        addr_reg    <= inst_addr;
        stride_reg  <= inst_stride_ls3;
        num_row_reg <= inst_num_row_m1;
        row_idx_reg <= '0;
      end else if (req_fire) begin
        addr_reg    <= addr_reg + stride_bytes;
        row_idx_reg <= row_idx_reg + BW_NUM_ROW_M1'(1);
      end
      // A request and a response in the same cycle cancel out.
      if (req_fire && !resp_fire) begin
        outstanding_reg <= outstanding_reg + BW_OUTSTANDING'(1);
      end else if (!req_fire && resp_fire) begin
        outstanding_reg <= outstanding_reg - BW_OUTSTANDING'(1);
      end
    end
  end

  // Completion pulse, coincident with the first IDLE cycle
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_DRAIN) && resp_fire && resp_last;
    end
  end

`ifdef DCA_LOAD_SEQ_ROW_CHECK_EN
  logic [BW_NUM_ROW_M1-1:0] exp_row_reg;
  logic                     seq_error_reg;
  logic [BW_TXN_INFO-1:0]   exp_tag;

  assign exp_tag   = {(exp_row_reg == num_row_reg), exp_row_reg};
  assign seq_error = seq_error_reg;

  // Expected-row tracker; any out-of-order tag latches seq_error until reset
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      exp_row_reg   <= '0;
      seq_error_reg <= 1'b0;
    end else begin
      if (inst_fire) begin
        exp_row_reg <= '0;
      end else if (resp_fire) begin
        exp_row_reg <= exp_row_reg + BW_NUM_ROW_M1'(1);
      end
      if (resp_fire && (rresp_txn_info != exp_tag)) begin
        seq_error_reg <= 1'b1;
      end
    end
  end
`else
  // Without the checker only the last bit of the returned tag matters.
  logic [BW_NUM_ROW_M1-1:0] unused_tag_bits;
  assign unused_tag_bits = rresp_txn_info[BW_NUM_ROW_M1-1:0];
  assign seq_error       = 1'b0;
`endif

endmodule

// File: tb/tb_dca_matrix_load_sequencer.sv
// tb_dca_matrix_load_sequencer
//  Randomised and directed stimulus for dca_matrix_load_sequencer, checked
//  every cycle against a row-counting reference model plus literal
//  expectations for the directed scenarios.
module tb_dca_matrix_load_sequencer;

  localparam int MAXO = 4;
`ifdef DCA_LOAD_SEQ_ROW_CHECK_EN
  localparam bit ROW_CHECK = 1'b1;
`else
  localparam bit ROW_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] inst_addr = '0;
  logic [23:0] inst_stride_ls3 = '0;
  logic [3:0]  inst_num_row_m1 = '0;
  logic        rreq_valid;
  logic        rreq_ready = 1'b0;
  logic [31:0] rreq_addr;
  logic [4:0]  rreq_txn_info;
  logic        rresp_valid = 1'b0;
  logic        rresp_ready;
  logic [4:0]  rresp_txn_info = '0;
  logic        busy;
  logic        done;
  logic        seq_error;

  dca_matrix_load_sequencer dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_addr       (inst_addr),
    .inst_stride_ls3 (inst_stride_ls3),
    .inst_num_row_m1 (inst_num_row_m1),
    .rreq_valid      (rreq_valid),
    .rreq_ready      (rreq_ready),
    .rreq_addr       (rreq_addr),
    .rreq_txn_info   (rreq_txn_info),
    .rresp_valid     (rresp_valid),
    .rresp_ready     (rresp_ready),
    .rresp_txn_info  (rresp_txn_info),
    .busy            (busy),
    .done            (done),
    .seq_error       (seq_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction = a list of rows; row i lives at
  // base + i*stride*8 and carries tag {i==rows-1, i}.
  bit          m_active = 1'b0;
  int          m_rows = 0;
  int          m_issued = 0;
  int          m_consumed = 0;
  logic [31:0] m_base = '0;
  logic [23:0] m_stride = '0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic [4:0]  pend_q[$];

  logic [31:0] req_addr_log[$];
  logic [4:0]  req_tag_log[$];
  int          req_cyc_log[$];
  int          resp_cyc_log[$];
  int          done_count = 0;
  int          cyc = 0;

  function automatic logic [4:0] row_tag(input int idx, input int rows);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {(idx == rows - 1), i4};
  endfunction

  function automatic logic [31:0] row_addr(input logic [31:0] base, input logic [23:0] stride, input int idx);
    logic [31:0] step;
    step = {8'd0, stride} << 3;
    return base + 32'(idx) * step;
  endfunction

  // Per-cycle comparison and model update (inputs are stable at negedge)
  always @(negedge clk) begin
    int outs;
    bit exp_rv, req_f, resp_f, inst_f, fin;
    cyc++;
    if (done) done_count++;
    if (!rstnn) begin
      check("rst_inst_ready", inst_ready, 1);
      check("rst_rreq_valid", rreq_valid, 0);
      check("rst_rreq_addr", rreq_addr, 0);
      check("rst_rreq_tag", rreq_txn_info, 0);
      check("rst_rresp_ready", rresp_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_seq_error", seq_error, 0);
      m_active = 0; m_issued = 0; m_consumed = 0; m_done = 0; m_err = 0;
      pend_q.delete();
    end else begin
      outs   = m_issued - m_consumed;
      exp_rv = m_active && (m_issued < m_rows) && (outs < MAXO);
      check("inst_ready", inst_ready, !m_active);
      check("busy", busy, m_active);
      check("rreq_valid", rreq_valid, exp_rv);
      check("rresp_ready", rresp_ready, m_active && (outs != 0));
      check("done", done, m_done);
      check("seq_error", seq_error, m_err);
      if (exp_rv) begin
        check("rreq_addr", rreq_addr, row_addr(m_base, m_stride, m_issued));
        check("rreq_tag", rreq_txn_info, row_tag(m_issued, m_rows));
      end
      req_f  = rreq_valid && rreq_ready;
      resp_f = rresp_valid && rresp_ready;
      inst_f = inst_valid && inst_ready;
      fin    = 0;
      if (resp_f) begin
        resp_cyc_log.push_back(cyc);
        if (ROW_CHECK && (rresp_txn_info != row_tag(m_consumed, m_rows))) m_err = 1;
        if (rresp_txn_info[4] && (m_issued == m_rows)) fin = 1;
        if (pend_q.size() > 0) void'(pend_q.pop_front());
        m_consumed++;
      end
      if (req_f) begin
        req_addr_log.push_back(rreq_addr);
        req_tag_log.push_back(rreq_txn_info);
        req_cyc_log.push_back(cyc);
        pend_q.push_back(row_tag(m_issued, m_rows));
        m_issued++;
      end
      if (fin) m_active = 0;
      m_done = fin;
      if (inst_f) begin
        m_active = 1; m_rows = int'(inst_num_row_m1) + 1;
        m_base = inst_addr; m_stride = inst_stride_ls3;
        m_issued = 0; m_consumed = 0;
        pend_q.delete();
      end
    end
  end

  // Memory-side driver: request backpressure and in-order responses
  int rdy_mode = 1;
  int resp_mode = 0;
  int stall_cnt = 0;
  bit corrupt = 1'b0;

  always begin
    logic [4:0] t;
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: rreq_ready = ($urandom_range(0, 3) != 0);
      3: begin
        if (m_issued == 2 && stall_cnt < 3) begin
          rreq_ready = 1'b0;
          stall_cnt++;
        end else begin
          rreq_ready = 1'b1;
        end
      end
      4: rreq_ready = (m_issued < 2);
      default: rreq_ready = 1'b1;
    endcase
    rresp_valid    = 1'b0;
    rresp_txn_info = 5'($urandom);
    if (pend_q.size() > 0) begin
      t = pend_q[0];
      if (corrupt && t[3:0] == 4'd2) t = 5'h01;
      rresp_txn_info = t;
      case (resp_mode)
        1: rresp_valid = ($urandom_range(0, 2) != 0);
        2: rresp_valid = 1'b1;
        3: begin rresp_valid = 1'b1; resp_mode = 0; end
        default: rresp_valid = 1'b0;
      endcase
    end else if (resp_mode == 1) begin
      rresp_valid = ($urandom_range(0, 7) == 0);
    end
  end

  task automatic clear_logs();
    req_addr_log.delete(); req_tag_log.delete();
    req_cyc_log.delete(); resp_cyc_log.delete();
  endtask

  task automatic start_inst(input logic [31:0] a, input logic [23:0] s, input logic [3:0] n);
    @(posedge clk); #1;
    inst_valid = 1'b1; inst_addr = a; inst_stride_ls3 = s; inst_num_row_m1 = n;
    @(posedge clk); #1;
    inst_valid = 1'b0; inst_addr = $urandom;
    inst_stride_ls3 = 24'($urandom); inst_num_row_m1 = 4'($urandom);
  endtask

  task automatic wait_done(input string name);
    int start = done_count;
    for (int i = 0; i < 2000 && done_count == start; i++) @(posedge clk);
    #1;
    check(name, done_count != start, 1);
    if (done_count == start) begin
      rstnn = 1'b0; @(posedge clk); #1; rstnn = 1'b1;
    end
  endtask

  task automatic check_reqs(input string name, input logic [31:0] a0, input logic [23:0] s, input int rows);
    check({name, "_nreq"}, req_addr_log.size(), rows);
    if (req_addr_log.size() == rows) begin
      for (int i = 0; i < rows; i++) begin
        check({name, "_addr"}, req_addr_log[i], a0 + 32'(i) * ({8'd0, s} << 3));
        check({name, "_tag"}, req_tag_log[i], {(i == rows - 1), 4'(i)});
      end
    end
  endtask

  initial begin
    int d0;
    logic [31:0] t1_addr[4];
    logic [4:0]  t1_tag[4];
    t1_addr = '{32'h1000, 32'h1020, 32'h1040, 32'h1060};
    t1_tag  = '{5'h00, 5'h01, 5'h02, 5'h13};

    repeat (3) @(posedge clk);
    #1 rstnn = 1'b1;

    // 1: four rows, responses echoed one cycle after each request
    clear_logs(); rdy_mode = 1; resp_mode = 2; d0 = done_count;
    start_inst(32'h1000, 24'd4, 4'd3);
    wait_done("t1_done_seen");
    repeat (3) @(posedge clk); #1;
    check("t1_nreq", req_addr_log.size(), 4);
    if (req_addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_addr", req_addr_log[i], t1_addr[i]);
        check("t1_tag", req_tag_log[i], t1_tag[i]);
      end
    end
    check("t1_done_pulses", done_count - d0, 1);
    check("t1_busy_low", busy, 0);

    // 2: outstanding limit with responses withheld, then one released
    clear_logs(); rdy_mode = 1; resp_mode = 0;
    start_inst(32'h2000, 24'd2, 4'd7);
    repeat (10) @(posedge clk); #1;
    check("t2_nreq_full", req_addr_log.size(), MAXO);
    check("t2_rreq_valid_full", rreq_valid, 0);
    resp_mode = 3;
    repeat (4) @(posedge clk); #1;
    check("t2_nreq_after_release", req_addr_log.size(), MAXO + 1);
    check("t2_logs_present", (req_cyc_log.size() > MAXO) && (resp_cyc_log.size() > 0), 1);
    if ((req_cyc_log.size() > MAXO) && (resp_cyc_log.size() > 0))
      check("t2_reissue_latency", req_cyc_log[MAXO] - resp_cyc_log[0], 1);
    resp_mode = 2;
    wait_done("t2_done_seen");
    check_reqs("t2", 32'h2000, 24'd2, 8);

    // 3: backpressure held for three cycles on row 2
    clear_logs(); rdy_mode = 3; stall_cnt = 0; resp_mode = 2;
    start_inst(32'h3000, 24'd2, 4'd3);
    wait_done("t3_done_seen");
    check("t3_stall_cycles", stall_cnt, 3);
    check_reqs("t3", 32'h3000, 24'd2, 4);
    rdy_mode = 1;

    // 4: address wrap, then a single-row instruction
    clear_logs();
    start_inst(32'hFFFF_FFE0, 24'd4, 4'd1);
    wait_done("t4_done_seen");
    check("t4_nreq", req_addr_log.size(), 2);
    if (req_addr_log.size() == 2) begin
      check("t4_addr0", req_addr_log[0], 32'hFFFF_FFE0);
      check("t4_addr1", req_addr_log[1], 32'h0000_0000);
    end
    clear_logs(); d0 = done_count;
    start_inst(32'h0000_0500, 24'd9, 4'd0);
    wait_done("t4_single_done_seen");
    check("t4_single_nreq", req_addr_log.size(), 1);
    if (req_tag_log.size() == 1) check("t4_single_tag", req_tag_log[0], 5'h10);
    check("t4_single_done_pulses", done_count - d0, 1);

    // 5: reset while two reads are outstanding
    clear_logs(); rdy_mode = 4; resp_mode = 0;
    start_inst(32'h4000, 24'd1, 4'd7);
    repeat (6) @(posedge clk); #1;
    check("t5_nreq_before_reset", req_addr_log.size(), 2);
    check("t5_rresp_ready_before", rresp_ready, 1);
    d0 = done_count;
    rstnn = 1'b0;
    #1;
    check("t5_async_rreq_valid", rreq_valid, 0);
    check("t5_async_inst_ready", inst_ready, 1);
    check("t5_async_busy", busy, 0);
    check("t5_async_rresp_ready", rresp_ready, 0);
    repeat (2) @(posedge clk); #1;
    rstnn = 1'b1; rdy_mode = 1; resp_mode = 2;
    repeat (3) @(posedge clk); #1;
    check("t5_no_done_after_reset", done_count - d0, 0);
    clear_logs();
    start_inst(32'h6000, 24'd3, 4'd2);
    wait_done("t5_next_done_seen");
    check_reqs("t5_next", 32'h6000, 24'd3, 3);

    // 6: row 2's response returned with row 1's tag
    clear_logs(); corrupt = 1'b1; d0 = done_count;
    start_inst(32'h7000, 24'd1, 4'd3);
    wait_done("t6_done_seen");
    corrupt = 1'b0;
    check("t6_done_pulses", done_count - d0, 1);
    check("t6_seq_error", seq_error, ROW_CHECK);
    start_inst(32'h7100, 24'd1, 4'd1);
    wait_done("t6_follow_done_seen");
    check("t6_seq_error_sticky", seq_error, ROW_CHECK);

    // Randomised instructions with random backpressure and response timing
    rdy_mode = 0; resp_mode = 1;
    for (int k = 0; k < 25; k++) begin
      logic [23:0] s;
      s = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 64)) : 24'($urandom);
      start_inst($urandom, s, 4'($urandom_range(0, 15)));
      wait_done("rand_done_seen");
    end
    repeat (4) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
